// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the MEM-stage data-bus access unit: FSM state
// encoding, access-size codes and the bus-size mapping helper.
package mem_access_unit_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } mau_state_e;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    // Size code 3 has no meaning on the bus and is issued as a word.
    function automatic logic [1:0] bus_size(input logic [1:0] size);
        logic [1:0] res;
        if (size == 2'd3) begin
            res = SZ_WORD;
        end else begin
            res = size;
        end
        return res;
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// SRAM-like data bus between the access unit (master) and memory (slave).
interface mem_access_unit_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              data_req;
    logic              data_wr;
    logic [1:0]        data_size;
    logic [ADDR_W-1:0] data_addr;
    logic [DATA_W-1:0] data_wdata;
    logic [3:0]        data_wstrb;
    logic              data_addr_ok;
    logic              data_data_ok;
    logic [DATA_W-1:0] data_rdata;

    modport master (
        output data_req, data_wr, data_size, data_addr, data_wdata, data_wstrb,
        input  data_addr_ok, data_data_ok, data_rdata
    );

    modport slave (
        input  data_req, data_wr, data_size, data_addr, data_wdata, data_wstrb,
        output data_addr_ok, data_data_ok, data_rdata
    );
endinterface

// File: rtl/mem_access_unit_chk.sv
// Protocol checker: the bus may only complete a data phase while a request
// is outstanding (REQ or WAIT).
module mem_access_unit_chk
    import mem_access_unit_pkg::*;
(
    input logic       clk,
    input logic       resetn,
    input mau_state_e state,
    input logic       data_ok
);

    property p_data_ok_in_phase;
        @(posedge clk) disable iff (!resetn)
            data_ok |-> (state == REQ || state == WAIT);
    endproperty

    a_data_ok_in_phase: assert property (p_data_ok_in_phase);

endmodule

// File: rtl/mem_access_unit_store_align.sv
// Store lane alignment: replicates store data across byte lanes, builds the
// byte strobes for the addressed lanes and flags misaligned addresses.
module mem_store_align
    import mem_access_unit_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    output logic [31:0] wdata_aligned,
    output logic [3:0]  wstrb,
    output logic        misaligned
);

    // Decode access size into lane replication, strobes and alignment fault.
    always_comb begin
        wdata_aligned = wdata;
        wstrb         = 4'b1111;
        misaligned    = 1'b0;
        case (size)
            SZ_BYTE: begin
                wdata_aligned = {4{wdata[7:0]}};
                wstrb         = 4'b0001 << addr_lo;
            end
            SZ_HALF: begin
                wdata_aligned = {2{wdata[15:0]}};
                wstrb         = 4'b0011 << addr_lo;
                misaligned    = addr_lo[0];
            end
            default: begin
                // Word and the size-3 alias both need a 4-byte boundary.
                misaligned = (addr_lo != 2'b00);
            end
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage data access unit: issues load/store requests on the data bus,
// holds the pipeline stall until the load word is captured in rdata, and
// reports misaligned addresses without touching the bus.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              mem_en,
    input  logic              mem_we,
    input  logic [1:0]        mem_size,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    mem_access_unit_if.master bus,
    output logic [DATA_W-1:0] rdata,
    output logic              stall,
    output logic              adel,
    output logic              ades,
    output logic [ADDR_W-1:0] badvaddr
);

    mau_state_e        state_r;
    mau_state_e        state_next_s;
    logic              req_r;
    logic              wr_r;
    logic [1:0]        size_r;
    logic [ADDR_W-1:0] addr_r;
    logic [DATA_W-1:0] wdata_r;
    logic [3:0]        wstrb_r;
    logic [DATA_W-1:0] rdata_r;
    logic [DATA_W-1:0] align_wdata_s;
    logic [3:0]        align_wstrb_s;
    logic              misaligned_s;
    logic              issue_s;
    logic              capture_s;

    mem_store_align u_align (
        .size          (mem_size),
        .addr_lo       (addr[1:0]),
        .wdata         (wdata),
        .wdata_aligned (align_wdata_s),
        .wstrb         (align_wstrb_s),
        .misaligned    (misaligned_s)
    );

    mem_access_unit_chk u_chk (
        .clk     (clk),
        .resetn  (resetn),
        .state   (state_r),
        .data_ok (bus.data_data_ok)
    );

    assign issue_s = (state_r == IDLE) && mem_en && !misaligned_s;

    // Next-state logic and load-data capture strobe.
    always_comb begin
        state_next_s = state_r;
        capture_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (issue_s) begin
                    state_next_s = REQ;
                end else begin
                    state_next_s = IDLE;
                end
            end
            REQ: begin
                if (bus.data_addr_ok && bus.data_data_ok) begin
                    state_next_s = DONE;
                    capture_s    = !wr_r;
                end else if (bus.data_addr_ok) begin
                    state_next_s = WAIT;
                end else begin
                    state_next_s = REQ;
                end
            end
            WAIT: begin
                if (bus.data_data_ok) begin
                    state_next_s = DONE;
                    capture_s    = !wr_r;
                end else begin
                    state_next_s = WAIT;
                end
            end
            DONE: begin
                // One non-stall cycle so the load-data register samples rdata.
                state_next_s = IDLE;
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Bus command registers: latched once at issue, held until the next issue.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            req_r   <= 1'b0;
            wr_r    <= 1'b0;
            size_r  <= 2'd0;
            addr_r  <= {ADDR_W{1'b0}};
            wdata_r <= {DATA_W{1'b0}};
            wstrb_r <= 4'b0000;
        end else begin
            req_r <= (state_next_s == REQ);
            if (issue_s) begin
                wr_r    <= mem_we;
                size_r  <= bus_size(mem_size);
                addr_r  <= addr;
                wdata_r <= align_wdata_s;
                wstrb_r <= mem_we ? align_wstrb_s : 4'b0000;
            end
        end
    end

    // Load-data register: raw bus word, untouched by stores.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rdata_r <= {DATA_W{1'b0}};
        end else if (capture_s) begin
            rdata_r <= bus.data_rdata;
        end
    end

    assign bus.data_req   = req_r;
    assign bus.data_wr    = wr_r;
    assign bus.data_size  = size_r;
    assign bus.data_addr  = addr_r;
    assign bus.data_wdata = wdata_r;
    assign bus.data_wstrb = wstrb_r;
    assign rdata          = rdata_r;

    assign stall    = issue_s || (state_r == REQ) || (state_r == WAIT);
    assign adel     = mem_en && !mem_we && misaligned_s && (state_r == IDLE);
    assign ades     = mem_en &&  mem_we && misaligned_s && (state_r == IDLE);
    assign badvaddr = addr;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: stimulus pushes expected bus
// requests and load results; a negedge monitor pops and compares them.
module tb_mem_access_unit;

    typedef struct {
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } req_t;

    logic        clk;
    logic        resetn;
    logic        mem_en;
    logic        mem_we;
    logic [1:0]  mem_size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        stall;
    logic        adel;
    logic        ades;
    logic [31:0] badvaddr;

    mem_access_unit_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_access_unit #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk      (clk),
        .resetn   (resetn),
        .mem_en   (mem_en),
        .mem_we   (mem_we),
        .mem_size (mem_size),
        .addr     (addr),
        .wdata    (wdata),
        .bus      (bus),
        .rdata    (rdata),
        .stall    (stall),
        .adel     (adel),
        .ades     (ades),
        .badvaddr (badvaddr)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    req_t        req_q[$];
    logic [31:0] done_q[$];
    logic [31:0] last_rd;

    // slave configuration
    int          addr_wait_cfg = 0;
    int          data_wait_cfg = 0;
    logic [31:0] rd_cfg        = 32'h0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Bus slave: responds #1 after each rising edge.
    initial begin
        int  aw_cnt;
        int  dw_cnt;
        bit  pending;
        aw_cnt  = 0;
        dw_cnt  = 0;
        pending = 1'b0;
        bus.data_addr_ok = 1'b0;
        bus.data_data_ok = 1'b0;
        bus.data_rdata   = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            bus.data_addr_ok = 1'b0;
            bus.data_data_ok = 1'b0;
            if (!resetn) begin
                pending = 1'b0;
                aw_cnt  = 0;
            end else if (pending) begin
                if (dw_cnt == 0) begin
                    bus.data_data_ok = 1'b1;
                    bus.data_rdata   = rd_cfg;
                    pending          = 1'b0;
                end else begin
                    dw_cnt--;
                end
            end else if (bus.data_req) begin
                if (aw_cnt >= addr_wait_cfg) begin
                    bus.data_addr_ok = 1'b1;
                    aw_cnt = 0;
                    if (data_wait_cfg == 0) begin
                        bus.data_data_ok = 1'b1;
                        bus.data_rdata   = rd_cfg;
                    end else begin
                        pending = 1'b1;
                        dw_cnt  = data_wait_cfg - 1;
                    end
                end else begin
                    aw_cnt++;
                end
            end
        end
    end

    // Monitor: compares accepted requests and completed accesses.
    initial begin
        req_t e;
        logic prev_stall;
        prev_stall = 1'b0;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                prev_stall = 1'b0;
            end else begin
                if (bus.data_req && bus.data_addr_ok) begin
                    chk("req_expected", 32'(req_q.size() > 0), 32'd1);
                    if (req_q.size() > 0) begin
                        e = req_q.pop_front();
                        chk("req_wr",    32'(bus.data_wr),    32'(e.wr));
                        chk("req_size",  32'(bus.data_size),  32'(e.size));
                        chk("req_addr",  bus.data_addr,       e.addr);
                        chk("req_wdata", bus.data_wdata,      e.wdata);
                        chk("req_wstrb", 32'(bus.data_wstrb), 32'(e.wstrb));
                    end
                end
                if (prev_stall && !stall) begin
                    chk("done_expected", 32'(done_q.size() > 0), 32'd1);
                    if (done_q.size() > 0) begin
                        chk("done_rdata", rdata, done_q.pop_front());
                    end
                end
                prev_stall = stall;
            end
        end
    end

    // Issue one aligned access and wait for the stall to drop (DONE).
    task automatic issue(input string tag, input logic t_we, input logic [1:0] t_size,
                         input logic [31:0] t_addr, input logic [31:0] t_wdata,
                         input logic [1:0] e_size, input logic [31:0] e_wdata,
                         input logic [3:0] e_wstrb, input logic [31:0] t_rd,
                         input int aw, input int dw, input int exp_stall);
        req_t e;
        int   n;
        bit   done;
        addr_wait_cfg = aw;
        data_wait_cfg = dw;
        rd_cfg        = t_rd;
        e.wr    = t_we;
        e.size  = e_size;
        e.addr  = t_addr;
        e.wdata = e_wdata;
        e.wstrb = e_wstrb;
        req_q.push_back(e);
        if (!t_we) last_rd = t_rd;
        done_q.push_back(last_rd);
        @(posedge clk);
        #1;
        mem_en   = 1'b1;
        mem_we   = t_we;
        mem_size = t_size;
        addr     = t_addr;
        wdata    = t_wdata;
        n    = 0;
        done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (stall) begin
                n++;
                if (bus.data_req) begin
                    chk({tag, "_req_addr_stable"}, bus.data_addr, t_addr);
                end
            end else begin
                done = 1'b1;
                chk({tag, "_req_low_in_done"}, 32'(bus.data_req), 32'd0);
            end
        end
        chk({tag, "_completed"}, 32'(done), 32'd1);
        chk({tag, "_stall_cycles"}, 32'(n), 32'(exp_stall));
    endtask

    // Present a misaligned access for a few cycles: no request, no stall.
    task automatic misaligned(input string tag, input logic t_we, input logic [1:0] t_size,
                              input logic [31:0] t_addr);
        @(posedge clk);
        #1;
        mem_en   = 1'b1;
        mem_we   = t_we;
        mem_size = t_size;
        addr     = t_addr;
        wdata    = 32'h0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk({tag, "_adel"},     32'(adel),         32'(!t_we));
            chk({tag, "_ades"},     32'(ades),         32'(t_we));
            chk({tag, "_badvaddr"}, badvaddr,          t_addr);
            chk({tag, "_stall"},    32'(stall),        32'd0);
            chk({tag, "_no_req"},   32'(bus.data_req), 32'd0);
        end
        @(posedge clk);
        #1;
        mem_en = 1'b0;
    endtask

    task automatic go_idle(input int cycles);
        @(posedge clk);
        #1;
        mem_en = 1'b0;
        repeat (cycles) @(posedge clk);
    endtask

    task automatic chk_regs_zero(input string tag);
        chk({tag, "_req"},   32'(bus.data_req),   32'd0);
        chk({tag, "_wr"},    32'(bus.data_wr),    32'd0);
        chk({tag, "_size"},  32'(bus.data_size),  32'd0);
        chk({tag, "_addr"},  bus.data_addr,       32'd0);
        chk({tag, "_wdata"}, bus.data_wdata,      32'd0);
        chk({tag, "_wstrb"}, 32'(bus.data_wstrb), 32'd0);
        chk({tag, "_rdata"}, rdata,               32'd0);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        resetn   = 1'b0;
        mem_en   = 1'b0;
        mem_we   = 1'b0;
        mem_size = 2'd0;
        addr     = 32'h0;
        wdata    = 32'h0;
        last_rd  = 32'h0;
        #2;
        chk_regs_zero("rst");
        chk("rst_stall_idle", 32'(stall), 32'd0);
        mem_en   = 1'b1;
        mem_size = 2'd2;
        #1;
        chk("rst_stall_follows_en", 32'(stall), 32'd1);
        mem_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;

        // word load, addr_ok+data_ok one cycle after req
        issue("ld_word", 1'b0, 2'd2, 32'h1000_0004, 32'h0, 2'd2, 32'h0, 4'b0000,
              32'hDEAD_BEEF, 1, 0, 3);
        // byte store at lane 3, rdata keeps the load word
        issue("st_byte3", 1'b1, 2'd0, 32'h0000_0003, 32'h1234_56AB, 2'd0, 32'hABAB_ABAB,
              4'b1000, 32'h0, 0, 0, 2);
        issue("st_byte1", 1'b1, 2'd0, 32'h0000_0001, 32'h0000_0077, 2'd0, 32'h7777_7777,
              4'b0010, 32'h0, 0, 0, 2);
        issue("st_half2", 1'b1, 2'd1, 32'h0000_0002, 32'h9999_BEEF, 2'd1, 32'hBEEF_BEEF,
              4'b1100, 32'h0, 0, 1, 3);
        issue("st_size3", 1'b1, 2'd3, 32'h0000_0008, 32'hA5A5_0F0F, 2'd2, 32'hA5A5_0F0F,
              4'b1111, 32'h0, 2, 0, 4);

        // misaligned accesses
        misaligned("ld_half_odd", 1'b0, 2'd1, 32'h0000_0001);
        misaligned("st_word_2",   1'b1, 2'd2, 32'h1000_0002);
        misaligned("ld_size3_3",  1'b0, 2'd3, 32'h0000_0003);
        misaligned("st_half_3",   1'b1, 2'd1, 32'h8000_0003);

        // addr_ok held low for 5 cycles
        issue("ld_addr_stall", 1'b0, 2'd2, 32'h2000_0008, 32'h0, 2'd2, 32'h0, 4'b0000,
              32'h1234_5678, 5, 0, 7);
        // split address / data phases through WAIT
        issue("ld_wait", 1'b0, 2'd2, 32'h0000_000C, 32'h0, 2'd2, 32'h0, 4'b0000,
              32'hCAFE_F00D, 0, 2, 4);
        issue("st_wait", 1'b1, 2'd2, 32'h0000_0010, 32'h0102_0304, 2'd2, 32'h0102_0304,
              4'b1111, 32'h0, 0, 1, 3);

        // back-to-back word stores
        issue("st_b2b_0", 1'b1, 2'd2, 32'h0000_0000, 32'h1111_1111, 2'd2, 32'h1111_1111,
              4'b1111, 32'h0, 0, 0, 2);
        issue("st_b2b_4", 1'b1, 2'd2, 32'h0000_0004, 32'h2222_2222, 2'd2, 32'h2222_2222,
              4'b1111, 32'h0, 0, 0, 2);
        go_idle(4);

        // reset while in WAIT
        addr_wait_cfg = 0;
        data_wait_cfg = 6;
        rd_cfg        = 32'h5555_AAAA;
        begin
            req_t e;
            e.wr = 1'b0; e.size = 2'd2; e.addr = 32'h3000_0010;
            e.wdata = 32'h0; e.wstrb = 4'b0000;
            req_q.push_back(e);
        end
        @(posedge clk);
        #1;
        mem_en   = 1'b1;
        mem_we   = 1'b0;
        mem_size = 2'd2;
        addr     = 32'h3000_0010;
        wdata    = 32'h0;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("wait_stall", 32'(stall), 32'd1);
        chk("wait_req_low", 32'(bus.data_req), 32'd0);
        resetn = 1'b0;
        #1;
        chk_regs_zero("rst_wait");
        chk("rst_wait_stall_en", 32'(stall), 32'd1);
        mem_en = 1'b0;
        #1;
        chk("rst_wait_stall_noen", 32'(stall), 32'd0);
        done_q.delete();
        last_rd = 32'h0;
        @(posedge clk);
        #1;
        resetn = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("post_rst_no_req", 32'(bus.data_req), 32'd0);
            chk("post_rst_stall", 32'(stall), 32'd0);
        end

        // recovery load after reset
        issue("ld_recover", 1'b0, 2'd2, 32'h0000_0004, 32'h0, 2'd2, 32'h0, 4'b0000,
              32'h0F0F_0F0F, 1, 0, 3);
        go_idle(4);

        chk("req_q_drained",  32'(req_q.size()),  32'd0);
        chk("done_q_drained", 32'(done_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
Data-memory access stage of the multicycle/pipelined MIPS core, directly upstream of the load-data register. It takes the MEM-stage load/store command and runs the SRAM-like data-bus handshake (req/addr_ok/data_ok). It aligns store data, generates byte strobes and detects misaligned addresses. It holds the pipeline stall high until the returned load word is valid on rdata, which the load-data register captures on the first non-stall edge.

Parameters:
ADDR_W, 32, address width of the command and data-bus address
DATA_W, 32, data word width (fixed 32 in this core; strobe logic assumes 4 bytes)

Ports:
clk  input  1  core clock, all state on rising edge
resetn  input  1  asynchronous active-low reset
mem_en  input  1  MEM-stage instruction is a load or store
mem_we  input  1  1 = store, 0 = load
mem_size  input  2  0 byte, 1 half, 2 word, 3 treated as word
addr  input  ADDR_W  effective address
wdata  input  DATA_W  store data (LSB-justified)
data_req  output  1  bus request
data_wr  output  1  bus write
data_size  output  2  bus size (copy of latched mem_size, 3 mapped to 2)
data_addr  output  ADDR_W  bus address (latched)
data_wdata  output  DATA_W  aligned store data (latched)
data_wstrb  output  4  byte strobes (latched; 0 for loads)
data_addr_ok  input  1  bus accepted request
data_data_ok  input  1  bus data phase complete
data_rdata  input  DATA_W  bus read data
rdata  output  DATA_W  registered raw load word to load-data register
stall  output  1  hold upstream pipeline / load-data register
adel  output  1  load address error (combinational)
ades  output  1  store address error (combinational)
badvaddr  output  ADDR_W  faulting address (= addr while adel/ades)

Behaviour:
- Reset (async, resetn=0): state IDLE; data_req 0; data_wr 0; data_size 0; data_addr 0; data_wdata 0; data_wstrb 0; rdata 0. stall/adel/ades are then functions of inputs only. An in-flight bus transaction is abandoned; the bus slave must be reset by the same resetn.
- misaligned = (size half & addr[0]) | (size word/3 & addr[1:0]!=0). adel = mem_en & ~mem_we & misaligned & state==IDLE; ades is the same with mem_we. A misaligned access issues no request and does not stall.
- States: IDLE, REQ, WAIT, DONE.
- IDLE: if mem_en & ~misaligned, latch addr/size/we/aligned wdata/wstrb and go to REQ. Otherwise stay.
- REQ: data_req=1, outputs stable. If addr_ok & data_ok in the same cycle, capture data_rdata into rdata (loads only) and go to DONE. If addr_ok alone, go to WAIT. Otherwise hold REQ with outputs unchanged.
- WAIT: data_req=0. On data_ok, capture rdata (loads only; stores leave rdata unchanged) and go to DONE.
- DONE: one cycle, go to IDLE unconditionally. The new MEM instruction is evaluated in the following IDLE.
- stall = (state==IDLE & mem_en & ~misaligned) | state==REQ | state==WAIT. stall=0 in DONE, so the load-data register samples rdata on that edge.
- Minimum load latency: IDLE→REQ→DONE = 2 stall cycles plus 1 DONE cycle.
- data_ok arriving in IDLE or DONE is ignored (protocol violation; an assertion flags it).
- Store alignment (a = addr[1:0]):
  - byte: wstrb = 4'b0001<<a, wdata = {4{wdata[7:0]}}
  - half: wstrb = 4'b0011<<a, wdata = {2{wdata[15:0]}}
  - word: wstrb = 4'b1111, wdata unchanged
- Loads: wstrb=0. rdata is the full raw word; byte/half extraction happens downstream.

Decomposition:
- Shared package: state encoding (IDLE=0, REQ=1, WAIT=2, DONE=3) and size constants SZ_BYTE=0, SZ_HALF=1, SZ_WORD=2.
- One combinational sub-module, mem_store_align (size, addr[1:0], wdata → aligned wdata, wstrb, misaligned), instantiated once.

Test Plan:
- Word load at 0x1000_0004, addr_ok and data_ok 1 cycle after req, rdata 0xDEAD_BEEF → stall high 3 cycles, rdata=0xDEADBEEF in DONE with stall=0, data_wstrb=0.
- Byte store 0xAB at 0x...0003 → data_wstrb=4'b1000, data_wdata=0xABABABAB, data_wr=1, rdata unchanged.
- Half load at 0x...0001 → adel=1, badvaddr=0x...0001, data_req never asserted, stall=0.
- addr_ok held low 5 cycles → data_req and data_addr stable throughout, stall high; then addr_ok+data_ok same cycle → DONE next edge.
- resetn pulsed low in WAIT → all registered outputs 0 immediately, state IDLE, stall follows mem_en.
- Back-to-back word stores to 0x0 and 0x4 → two separate req phases separated by DONE+IDLE, and neither store is issued twice.
